// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, scan
// result kinds, key-code constants, switch-to-code map and entry-register update.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_t;

    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } scan_res_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Switch index is {row, col}; returns the printed legend's code.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = KEY_A;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = KEY_B;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'h0;
            4'd14:   code = KEY_HASH;
            4'd15:   code = KEY_D;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Digits shift in at the right, '*' clears, '#' deletes the newest digit.
    function automatic logic [15:0] bcd_update(input logic [15:0] bcd,
                                               input logic [3:0]  code);
        logic [15:0] nxt;
        if (code <= 4'd9) begin
            nxt = {bcd[11:0], code};
        end else if (code == KEY_STAR) begin
            nxt = 16'h0000;
        end else if (code == KEY_HASH) begin
            nxt = {4'h0, bcd[15:4]};
        end else begin
            nxt = bcd;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_decode.sv
// Classifies a full 16-switch snapshot as no key, exactly one key (with its
// code) or several keys.
module key_decode
    import keypad_pkg::*;
(
    input  logic [15:0] i_sw,
    output scan_res_t   o_res
);

    logic [4:0] w_count;
    logic [3:0] w_code;

    // Count closed switches and remember the code of the last one seen.
    always_comb begin
        w_count = 5'd0;
        w_code  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_sw[i]) begin
                w_count = w_count + 5'd1;
                w_code  = key_code(4'(i));
            end else begin
                w_count = w_count;
            end
        end
    end

    // Map the count onto the result kind.
    always_comb begin
        o_res.code = w_code;
        case (w_count)
            5'd0:    o_res.kind = RES_NONE;
            5'd1:    o_res.kind = RES_SINGLE;
            default: o_res.kind = RES_MULTI;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and a 4-digit
// BCD entry register that feeds the seven-segment driver.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_BITS = 8,
    parameter int DEB_SCANS = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o,
    output logic [15:0] bcd_o
);

    localparam logic [3:0] DEB = 4'(DEB_SCANS);

    logic [3:0]           r_row_meta;
    logic [3:0]           r_row_sync;
    logic [SCAN_BITS-1:0] r_presc;
    logic [1:0]           r_col;
    logic [3:0]           r_col_o;
    logic [15:0]          r_sw;
    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [3:0]           r_cand;
    logic                 r_valid;
    logic [3:0]           r_code;
    logic [15:0]          r_bcd;

    logic                 w_scan_edge;
    logic                 w_scan_end;
    logic [15:0]          w_sw_next;
    scan_res_t            w_res;

    assign w_scan_edge = &r_presc;
    assign w_scan_end  = w_scan_edge && (r_col == 2'd3);

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_i;
            r_row_sync <= r_row_meta;
        end
    end

    // Prescaler and column stepper; the column drive rotates one place per scan edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_col   <= 2'd0;
            r_col_o <= 4'b1110;
        end else begin
            r_presc <= r_presc + SCAN_BITS'(1);
            if (w_scan_edge) begin
                r_col   <= r_col + 2'd1;
                r_col_o <= {r_col_o[2:0], r_col_o[3]};
            end else begin
                r_col   <= r_col;
                r_col_o <= r_col_o;
            end
        end
    end

    // Snapshot with the current column's rows merged in, so the scan-end
    // decision already sees column 3.
    always_comb begin
        w_sw_next = r_sw;
        for (int r = 0; r < 4; r++) begin
            w_sw_next[4'(r * 4) + {2'b00, r_col}] = ~r_row_sync[r];
        end
    end

    // Switch matrix latch, one column per scan edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw <= 16'h0000;
        end else if (w_scan_edge) begin
            r_sw <= w_sw_next;
        end else begin
            r_sw <= r_sw;
        end
    end

    key_decode u_key_decode (
        .i_sw  (w_sw_next),
        .o_res (w_res)
    );

    // Debounce FSM with registered key pulse, code and entry register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_cand  <= 4'h0;
            r_valid <= 1'b0;
            r_code  <= 4'h0;
            r_bcd   <= 16'h0000;
        end else begin
            r_valid <= 1'b0;
            if (w_scan_end) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_res.kind == RES_SINGLE) begin
                            r_cand <= w_res.code;
                            if (DEB_SCANS == 1) begin
                                r_valid <= 1'b1;
                                r_code  <= w_res.code;
                                r_bcd   <= bcd_update(r_bcd, w_res.code);
                                r_state <= ST_HELD;
                                r_cnt   <= 4'd0;
                            end else begin
                                r_state <= ST_DEBOUNCE;
                                r_cnt   <= 4'd1;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if ((w_res.kind == RES_SINGLE) && (w_res.code == r_cand)) begin
                            if ((r_cnt + 4'd1) == DEB) begin
                                r_valid <= 1'b1;
                                r_code  <= r_cand;
                                r_bcd   <= bcd_update(r_bcd, r_cand);
                                r_state <= ST_HELD;
                                r_cnt   <= 4'd0;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 4'd0;
                        end
                    end
                    ST_HELD: begin
                        if (w_res.kind == RES_NONE) begin
                            if ((r_cnt + 4'd1) == DEB) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= 4'd0;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign col_o       = r_col_o;
    assign key_valid_o = r_valid;
    assign key_code_o  = r_code;
    assign bcd_o       = r_bcd;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes switches against col_o;
// expected pulses are queued at stimulus time and popped by a pulse monitor.
module tb_keypad_scanner;

    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_s;
    logic [3:0]  col_o;
    logic        key_valid_o;
    logic [3:0]  key_code_o;
    logic [15:0] bcd_o;

    logic [15:0] pressed = 16'h0000;
    logic [19:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    keypad_scanner #(.SCAN_BITS(2), .DEB_SCANS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_s),
        .col_o       (col_o),
        .key_valid_o (key_valid_o),
        .key_code_o  (key_code_o),
        .bcd_o       (bcd_o)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed switch pulls its row low while its column is driven low.
    always_comb begin
        row_s = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && (col_o[c] == 1'b0)) row_s[r] = 1'b0;
            end
        end
    end

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [19:0] e;
        if (key_valid_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got code=%h bcd=%h, none expected", key_code_o, bcd_o);
            end else begin
                e = exp_q.pop_front();
                if ({key_code_o, bcd_o} !== e) begin
                    bad++;
                    $display("FAIL pulse: got code=%h bcd=%h, need code=%h bcd=%h",
                             key_code_o, bcd_o, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, need %h", name, got, want);
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(posedge clk);
        #1;
    endtask

    // Press one switch, expect one pulse, release long enough to re-arm.
    task automatic key(input int idx, input logic [3:0] code, input logic [15:0] bcd);
        exp_q.push_back({code, bcd});
        pressed[idx] = 1'b1;
        wait_scans(5);
        pressed[idx] = 1'b0;
        wait_scans(4);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_col", {28'd0, col_o}, {28'd0, 4'b1110});
        check("rst_bcd", {16'd0, bcd_o}, 32'h0000_0000);
        check("rst_valid", {31'd0, key_valid_o}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] one_hot;
        // Reset and column stepping.
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", {28'd0, col_o}, {28'd0, 4'b1110});
        check("rst_bcd", {16'd0, bcd_o}, 32'h0000_0000);
        check("rst_valid", {31'd0, key_valid_o}, 32'd0);
        check("rst_code", {28'd0, key_code_o}, 32'd0);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            one_hot = 4'b0001 << ((n / 4) % 4);
            check("col_step", {28'd0, col_o}, {28'd0, ~one_hot});
        end

        // Digit entry: 5 held 6 scans, then 7, 2, 9, 3.
        exp_q.push_back({4'h5, 16'h0005});
        pressed[5] = 1'b1;
        wait_scans(6);
        pressed[5] = 1'b0;
        wait_scans(4);
        check("key5_code", {28'd0, key_code_o}, 32'h5);
        key(8,  4'h7, 16'h0057);
        key(1,  4'h2, 16'h0572);
        key(10, 4'h9, 16'h5729);
        key(2,  4'h3, 16'h7293);

        // Bounce: 8 closed for one scan only.
        @(posedge clk);
        #1;
        pressed[9] = 1'b1;
        repeat (SCAN) @(posedge clk);
        #1;
        pressed[9] = 1'b0;
        wait_scans(4);
        check("bounce_bcd", {16'd0, bcd_o}, 32'h0000_7293);

        // Edit keys.
        key(14, 4'hF, 16'h0729);
        key(12, 4'hE, 16'h0000);
        key(3,  4'hA, 16'h0000);
        check("keyA_code", {28'd0, key_code_o}, 32'hA);

        // Multi-key: 1+2 together, then 2 released with 1 still held.
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        wait_scans(4);
        check("multi_nopulse_q", exp_q.size(), 32'd0);
        exp_q.push_back({4'h1, 16'h0001});
        pressed[1] = 1'b0;
        wait_scans(5);
        pressed[0] = 1'b0;
        wait_scans(4);
        check("multi_bcd", {16'd0, bcd_o}, 32'h0000_0001);

        // Reset mid-hold: 4 accepted, reset while still held, re-reported.
        do_reset(3);
        exp_q.push_back({4'h4, 16'h0004});
        pressed[4] = 1'b1;
        wait_scans(5);
        check("hold4_consumed", exp_q.size(), 32'd0);
        check("hold4_bcd", {16'd0, bcd_o}, 32'h0000_0004);
        do_reset(1);
        exp_q.push_back({4'h4, 16'h0004});
        wait_scans(5);
        pressed[4] = 1'b0;
        wait_scans(4);
        check("rereport_bcd", {16'd0, bcd_o}, 32'h0000_0004);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
